// File: rtl/dcm_pkg.sv
// Shared definitions for the DCM frequency-programming controller and the DCM itself:
// FSM encodings, frequency-code width and the per-code CLKFX divider constants.
package dcm_pkg;

    localparam int CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // CLKFX_DIVIDE values the DCM applies for each frequency code
    localparam logic [7:0] CLOCK_0 = 8'd32;
    localparam logic [7:0] CLOCK_1 = 8'd28;
    localparam logic [7:0] CLOCK_2 = 8'd24;
    localparam logic [7:0] CLOCK_3 = 8'd20;
    localparam logic [7:0] CLOCK_4 = 8'd16;
    localparam logic [7:0] CLOCK_5 = 8'd12;
    localparam logic [7:0] CLOCK_6 = 8'd8;
    localparam logic [7:0] CLOCK_7 = 8'd4;

    function automatic logic [7:0] clock_div(code_t c);
        case (c)
            3'd0:    return CLOCK_0;
            3'd1:    return CLOCK_1;
            3'd2:    return CLOCK_2;
            3'd3:    return CLOCK_3;
            3'd4:    return CLOCK_4;
            3'd5:    return CLOCK_5;
            3'd6:    return CLOCK_6;
            default: return CLOCK_7;
        endcase
    endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// Button, feedback-clock and DCM programming signals of the controller.
// master = controller side, slave = buttons/DCM side.
import dcm_pkg::*;

interface dcm_prog_ctrl_if;
    logic  btn_up;
    logic  btn_down;
    logic  clk2_fb;
    code_t prog;
    logic  update;
    code_t sel;
    logic  busy;
    logic  done;
    logic  err;

    modport master (
        input  btn_up, btn_down, clk2_fb,
        output prog, update, sel, busy, done, err
    );

    modport slave (
        output btn_up, btn_down, clk2_fb,
        input  prog, update, sel, busy, done, err
    );
endinterface

// File: rtl/dcm_prog_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic [2:0] sr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= {sr[1:0], d};
    end

    assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/dcm_prog_ctrl.sv
// Steps the DCM frequency code up/down on button edges and confirms lock via clk2_fb edges.
// Define DCM_PROG_CTRL_WRAP_EN to wrap codes 7<->0 instead of saturating.
import dcm_pkg::*;

module dcm_prog_ctrl #(
    parameter int SETTLE_EDGES = 2,
    parameter int TIMEOUT_CYC  = 400_000_000
) (
    input logic              clock,
    input logic              reset,
    dcm_prog_ctrl_if.master  dcm
);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int EDGE_W = $clog2(SETTLE_EDGES + 1);

    state_t             state, state_nx;
    logic               up_q, dn_q;
    code_t              prog_q, sel_q, nx_code;
    logic               err_q, hit_q;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic               fb_rise, up_edge, dn_edge, req, cnt_hit, to_hit;

    sync_edge u_fb_sync (.clock(clock), .reset(reset), .d(dcm.clk2_fb), .rise(fb_rise));

    assign up_edge = dcm.btn_up   & ~up_q;
    assign dn_edge = dcm.btn_down & ~dn_q;
    assign cnt_hit = (edge_cnt == EDGE_W'(SETTLE_EDGES));
    assign to_hit  = (cyc_cnt  == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        nx_code = sel_q;
`ifdef DCM_PROG_CTRL_WRAP_EN
        if (up_edge)      nx_code = sel_q + 1'b1;
        else if (dn_edge) nx_code = sel_q - 1'b1;
`else
        if (up_edge && sel_q != '1)      nx_code = sel_q + 1'b1;
        else if (dn_edge && sel_q != '0) nx_code = sel_q - 1'b1;
`endif
        // simultaneous edges cancel; a saturated step is not a request
        req = (up_edge ^ dn_edge) && (nx_code != sel_q);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = LOAD;
            LOAD:    state_nx = SETTLE;
            SETTLE:  if (cnt_hit || to_hit) state_nx = CHECK;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            prog_q   <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            hit_q    <= 1'b0;
            cyc_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            state <= state_nx;
            up_q  <= dcm.btn_up;
            dn_q  <= dcm.btn_down;
            if (state == IDLE && req) begin
                prog_q   <= nx_code;
                cyc_cnt  <= '0;
                edge_cnt <= '0;
            end
            if (state == SETTLE) begin
                cyc_cnt <= cyc_cnt + 1'b1;
                if (fb_rise) edge_cnt <= edge_cnt + 1'b1;
                // last SETTLE cycle leaves the match flag; match beats timeout
                hit_q <= cnt_hit;
            end
            if (state == CHECK) begin
                sel_q <= prog_q;
                err_q <= ~hit_q;
            end
        end
    end

    assign dcm.prog   = prog_q;
    assign dcm.sel    = sel_q;
    assign dcm.err    = err_q;
    assign dcm.update = (state == LOAD);
    assign dcm.busy   = (state != IDLE);
    assign dcm.done   = (state == CHECK) && hit_q;
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a behavioural DCM feedback clock.
import dcm_pkg::*;

module tb_dcm_prog_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   fb_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   upd_cnt = 0;
    int   done_cnt = 0;
    code_t dcm_code;

    dcm_prog_ctrl_if dif ();

    dcm_prog_ctrl #(.SETTLE_EDGES(2), .TIMEOUT_CYC(1000)) dut (
        .clock (clock),
        .reset (reset),
        .dcm   (dif)
    );

    always #5 clock = ~clock;

    // DCM model: loads prog on update, runs its output clock only while locked (fb_en)
    always begin
        #7;
        if (fb_en) dif.clk2_fb = ~dif.clk2_fb;
        else       dif.clk2_fb = 1'b0;
    end

    always @(posedge clock or posedge reset) begin
        if (reset)           dcm_code <= '0;
        else if (dif.update) dcm_code <= dif.prog;
    end

    always @(posedge clock) begin
        if (dif.update) upd_cnt  <= upd_cnt + 1;
        if (dif.done)   done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic code_t model_next(code_t s, bit up);
`ifdef DCM_PROG_CTRL_WRAP_EN
        return up ? code_t'(s + 3'd1) : code_t'(s - 3'd1);
`else
        if (up) return (s == 3'd7) ? s : code_t'(s + 3'd1);
        else    return (s == 3'd0) ? s : code_t'(s - 3'd1);
`endif
    endfunction

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clock);
            if (dif.done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    code_t msel = '0;

    task automatic pulse(input bit up, input bit dn);
        @(negedge clock);
        dif.btn_up   = up;
        dif.btn_down = dn;
        @(negedge clock);
        dif.btn_up   = 1'b0;
        dif.btn_down = 1'b0;
    endtask

    // one button request; checks either a full LOAD/SETTLE/CHECK or a dropped saturated step
    task automatic req(input bit up);
        code_t nx = model_next(msel, up);
        int u0 = upd_cnt;
        int d0 = done_cnt;
        pulse(up, !up);
        if (nx == msel) begin
            repeat (10) @(negedge clock);
            chk("sat_no_update", 32'(upd_cnt), 32'(u0));
            chk("sat_sel_hold", 32'(dif.sel), 32'(msel));
            chk("sat_idle", 32'(dif.busy), 32'd0);
        end else begin
            chk("req_update", 32'(dif.update), 32'd1);
            chk("req_prog", 32'(dif.prog), 32'(nx));
            chk("req_busy", 32'(dif.busy), 32'd1);
            fb_en = 1'b1;
            wait_done(200);
            fb_en = 1'b0;
            @(negedge clock);
            chk("req_sel", 32'(dif.sel), 32'(nx));
            chk("req_idle", 32'(dif.busy), 32'd0);
            chk("req_err_clear", 32'(dif.err), 32'd0);
            chk("req_one_update", 32'(upd_cnt), 32'(u0 + 1));
            chk("req_one_done", 32'(done_cnt), 32'(d0 + 1));
            chk("dcm_code", 32'(dcm_code), 32'(nx));
            msel = nx;
        end
    endtask

    initial begin
        code_t nx;
        int u0, d0, n;
        dif.btn_up   = 1'b0;
        dif.btn_down = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_prog", 32'(dif.prog), 32'd0);
        chk("rst_sel", 32'(dif.sel), 32'd0);
        chk("rst_update", 32'(dif.update), 32'd0);
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_done", 32'(dif.done), 32'd0);
        chk("rst_err", 32'(dif.err), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // climb to code 7, then step past the top and back down
        for (int i = 0; i < 7; i++) req(1'b1);
        chk("at_top", 32'(dif.sel), 32'd7);
        req(1'b1);
        req(1'b0);

        // no feedback clock: timeout after 1000 SETTLE cycles
        nx = model_next(msel, 1'b1);
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        chk("to_update", 32'(dif.update), 32'd1);
        chk("to_prog", 32'(dif.prog), 32'(nx));
        n = 0;
        while (dif.busy && n < 1100) begin
            @(negedge clock);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd1002);
        chk("to_err", 32'(dif.err), 32'd1);
        chk("to_sel", 32'(dif.sel), 32'(nx));
        chk("to_no_done", 32'(done_cnt), 32'(d0));
        msel = nx;
        req(1'b0);

        // down edge during SETTLE is dropped
        nx = model_next(msel, 1'b1);
        u0 = upd_cnt;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        chk("drop_update", 32'(dif.update), 32'd1);
        repeat (3) @(negedge clock);
        chk("drop_settle_busy", 32'(dif.busy), 32'd1);
        pulse(1'b0, 1'b1);
        repeat (3) @(negedge clock);
        fb_en = 1'b1;
        wait_done(200);
        fb_en = 1'b0;
        @(negedge clock);
        chk("drop_sel", 32'(dif.sel), 32'(nx));
        chk("drop_one_update", 32'(upd_cnt), 32'(u0 + 1));
        chk("drop_one_done", 32'(done_cnt), 32'(d0 + 1));
        msel = nx;
        repeat (5) @(negedge clock);
        chk("drop_no_late_req", 32'(upd_cnt), 32'(u0 + 1));

        // simultaneous up+down in IDLE
        u0 = upd_cnt;
        pulse(1'b1, 1'b1);
        repeat (10) @(negedge clock);
        chk("both_no_update", 32'(upd_cnt), 32'(u0));
        chk("both_idle", 32'(dif.busy), 32'd0);
        chk("both_sel", 32'(dif.sel), 32'(msel));

        // reset mid-SETTLE with btn_up held across it
        pulse(1'b0, 1'b1);
        chk("mid_update", 32'(dif.update), 32'd1);
        repeat (4) @(negedge clock);
        chk("mid_busy", 32'(dif.busy), 32'd1);
        d0 = done_cnt;
        dif.btn_up = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_prog", 32'(dif.prog), 32'd0);
        chk("mid_rst_sel", 32'(dif.sel), 32'd0);
        chk("mid_rst_update", 32'(dif.update), 32'd0);
        chk("mid_rst_busy", 32'(dif.busy), 32'd0);
        chk("mid_rst_done", 32'(dif.done), 32'd0);
        chk("mid_rst_err", 32'(dif.err), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        msel = '0;
        u0 = upd_cnt;
        @(negedge clock);
        chk("held_update", 32'(dif.update), 32'd1);
        chk("held_prog", 32'(dif.prog), 32'd1);
        chk("held_no_stale_done", 32'(done_cnt), 32'(d0));
        repeat (5) @(negedge clock);
        fb_en = 1'b1;
        wait_done(200);
        fb_en = 1'b0;
        @(negedge clock);
        chk("held_sel", 32'(dif.sel), 32'd1);
        repeat (5) @(negedge clock);
        chk("held_one_update", 32'(upd_cnt), 32'(u0 + 1));
        chk("held_one_done", 32'(done_cnt), 32'(d0 + 1));
        dif.btn_up = 1'b0;
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
